baccarat_deal_fsm: RTL and testbench

- Sequencing controller for one baccarat hand.
- Drives the six card-register load enables in dealing order: P1, D1, P2, D2, then optional P3/D3.
- Applies the natural, player third-card and banker third-card rules using the scores from two scorehand instances (player, dealer).
- Latches the win lights at end of hand; holds until reset.

---
 rtl/baccarat_deal_fsm.sv | 100 ++++++++++
 tb/tb_baccarat_deal_fsm.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/baccarat_deal_fsm.sv
// Sequencer for one baccarat hand: deals P1/D1/P2/D2, applies the natural,
// player third-card and banker third-card rules, then latches the win lights.
module baccarat_deal_fsm (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       deal_en,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       hand_done
);

    typedef enum logic [3:0] {
        S_P1     = 4'd0,
        S_D1     = 4'd1,
        S_P2     = 4'd2,
        S_D2     = 4'd3,
        S_CHK    = 4'd4,
        S_P3     = 4'd5,
        S_BCHK   = 4'd6,
        S_D3     = 4'd7,
        S_RESULT = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    state_t     state_reg;
    logic       load_ok;
    logic [3:0] p3_val;
    logic       bank_draw;

    // Loads are combinational so the card register captures on the same edge the FSM advances.
    assign load_ok     = deal_en & ~reset;
    assign load_pcard1 = (state_reg == S_P1) & load_ok;
    assign load_dcard1 = (state_reg == S_D1) & load_ok;
    assign load_pcard2 = (state_reg == S_P2) & load_ok;
    assign load_dcard2 = (state_reg == S_D2) & load_ok;
    assign load_pcard3 = (state_reg == S_P3) & load_ok;
    assign load_dcard3 = (state_reg == S_D3) & load_ok;

    // Face cards and tens count as zero for the banker rule.
    assign p3_val = (pcard3 > 4'd9) ? 4'd0 : pcard3;

    always_comb begin
        bank_draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: bank_draw = 1'b1;
            4'd3:    bank_draw = (p3_val != 4'd8);
            4'd4:    bank_draw = (p3_val >= 4'd2) && (p3_val <= 4'd7);
            4'd5:    bank_draw = (p3_val >= 4'd4) && (p3_val <= 4'd7);
            4'd6:    bank_draw = (p3_val >= 4'd6) && (p3_val <= 4'd7);
            default: bank_draw = 1'b0;
        endcase
    end

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state_reg        <= S_P1;
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
            hand_done        <= 1'b0;
        end else begin
            case (state_reg)
                S_P1: if (deal_en) state_reg <= S_D1;
                S_D1: if (deal_en) state_reg <= S_P2;
                S_P2: if (deal_en) state_reg <= S_D2;
                S_D2: if (deal_en) state_reg <= S_CHK;
                S_CHK: begin
                    if ((pscore >= 4'd8) || (dscore >= 4'd8))
                        state_reg <= S_RESULT;
                    else if (pscore <= 4'd5)
                        state_reg <= S_P3;
                    else if (dscore <= 4'd5)
                        state_reg <= S_D3;
                    else
                        state_reg <= S_RESULT;
                end
                S_P3: if (deal_en) state_reg <= S_BCHK;
                S_BCHK: state_reg <= bank_draw ? S_D3 : S_RESULT;
                S_D3: if (deal_en) state_reg <= S_RESULT;
                S_RESULT: begin
                    player_win_light <= (pscore >= dscore);
                    dealer_win_light <= (dscore >= pscore);
                    hand_done        <= 1'b1;
                    state_reg        <= S_DONE;
                end
                S_DONE:  state_reg <= S_DONE;
                default: state_reg <= S_P1;
            endcase
        end
    end

endmodule

// File: tb/tb_baccarat_deal_fsm.sv
// Self-checking bench: card registers and scorehand modelled around the FSM,
// table of whole hands plus hand-written latency, stall and reset sequences.
module tb_baccarat_deal_fsm;

    logic       slow_clock = 1'b0;
    logic       reset = 1'b1;
    logic       deal_en = 1'b0;
    logic [3:0] pscore, dscore, pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light, hand_done;

    int checks = 0;
    int errors = 0;

    always #5 slow_clock = ~slow_clock;

    baccarat_deal_fsm dut (
        .slow_clock       (slow_clock),
        .reset            (reset),
        .deal_en          (deal_en),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .hand_done        (hand_done)
    );

    typedef struct {
        string      name;
        logic [3:0] p1, p2, p3, d1, d2, d3;
        logic       exp_p3, exp_d3, exp_pw, exp_dw;
        int         max_done;
    } hand_t;

    hand_t vec[11];
    hand_t cur;

    // Card registers and scorehand model surrounding the FSM.
    logic [3:0] p1_r, p2_r, p3_r, d1_r, d2_r, d3_r;

    always @(posedge slow_clock) begin
        if (reset) begin
            p1_r <= 4'd0; p2_r <= 4'd0; p3_r <= 4'd0;
            d1_r <= 4'd0; d2_r <= 4'd0; d3_r <= 4'd0;
        end else begin
            if (load_pcard1) p1_r <= cur.p1;
            if (load_pcard2) p2_r <= cur.p2;
            if (load_pcard3) p3_r <= cur.p3;
            if (load_dcard1) d1_r <= cur.d1;
            if (load_dcard2) d2_r <= cur.d2;
            if (load_dcard3) d3_r <= cur.d3;
        end
    end

    function automatic logic [4:0] cv(input logic [3:0] c);
        return (c > 4'd9) ? 5'd0 : {1'b0, c};
    endfunction

    function automatic logic [3:0] score3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        logic [4:0] s;
        s = cv(a) + cv(b) + cv(c);
        return 4'((s >= 5'd20) ? s - 5'd20 : (s >= 5'd10) ? s - 5'd10 : s);
    endfunction

    assign pscore = score3(p1_r, p2_r, p3_r);
    assign dscore = score3(d1_r, d2_r, d3_r);
    assign pcard3 = p3_r;

    function automatic logic [5:0] loads();
        return {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3};
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    task automatic tick();
        @(posedge slow_clock);
        #1;
    endtask

    task automatic start_hand(input hand_t h);
        cur = h;
        deal_en = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic run_hand(input int idx);
        logic sp3, sd3, multi;
        int   done_cyc;
        start_hand(vec[idx]);
        sp3 = 1'b0; sd3 = 1'b0; multi = 1'b0; done_cyc = -1;
        for (int c = 0; c < 16; c++) begin
            if (hand_done) begin
                done_cyc = c;
                break;
            end
            if ($countones(loads()) > 1) multi = 1'b1;
            if (load_pcard3) sp3 = 1'b1;
            if (load_dcard3) sd3 = 1'b1;
            tick();
        end
        chk({cur.name, " done_in_time"}, 8'((done_cyc >= 0) && (done_cyc <= cur.max_done)), 8'd1);
        chk({cur.name, " one_load"}, 8'(multi), 8'd0);
        chk({cur.name, " p3_loaded"}, 8'(sp3), 8'(cur.exp_p3));
        chk({cur.name, " d3_loaded"}, 8'(sd3), 8'(cur.exp_d3));
        chk({cur.name, " lights"}, {6'd0, player_win_light, dealer_win_light}, {6'd0, cur.exp_pw, cur.exp_dw});
        tick();
        tick();
        chk({cur.name, " done_hold"}, {loads(), hand_done, player_win_light},
            {6'd0, 1'b1, cur.exp_pw});
    endtask

    logic [5:0] nat_loads[7];

    initial begin
        //        name          p1 p2 p3  d1 d2 d3 xp3 xd3 pw dw max
        vec[0]  = '{"natural_p8",  4, 4, 0,  3, 2, 0, 0, 0, 1, 0, 6};
        vec[1]  = '{"pstand_bdraw",3, 3, 0,  2, 1, 2, 0, 1, 1, 0, 10};
        vec[2]  = '{"full_face",   2, 1, 12, 1, 2, 3, 1, 1, 0, 1, 10};
        vec[3]  = '{"b3_v8_stand", 1, 1, 8,  2, 1, 0, 1, 0, 0, 1, 10};
        vec[4]  = '{"b6_v5_stand", 1, 1, 5,  3, 3, 0, 1, 0, 1, 0, 10};
        vec[5]  = '{"tie_77",      2, 2, 3,  3, 4, 0, 1, 0, 1, 1, 10};
        vec[6]  = '{"dnatural_9",  1, 2, 0,  4, 5, 0, 0, 0, 0, 1, 6};
        vec[7]  = '{"b4_v2_draw",  0, 1, 2,  2, 2, 1, 1, 1, 0, 1, 10};
        vec[8]  = '{"b2_draw",     3, 2, 1,  1, 1, 5, 1, 1, 0, 1, 10};
        vec[9]  = '{"both_stand",  3, 4, 0,  2, 4, 0, 0, 0, 1, 0, 10};
        vec[10] = '{"b5_v15_stand",0, 0, 15, 2, 3, 0, 1, 0, 0, 1, 10};

        nat_loads[0] = 6'b100000; nat_loads[1] = 6'b010000;
        nat_loads[2] = 6'b001000; nat_loads[3] = 6'b000100;
        nat_loads[4] = 6'b000000; nat_loads[5] = 6'b000000;
        nat_loads[6] = 6'b000000;

        // Reset state
        cur = vec[0];
        reset = 1'b1;
        deal_en = 1'b1;
        tick();
        tick();
        chk("reset_outputs", {loads(), hand_done, player_win_light | dealer_win_light}, 8'd0);

        for (int i = 0; i < 11; i++) run_hand(i);

        // Natural: exact cycle-by-cycle loads and light latency
        start_hand(vec[0]);
        for (int c = 0; c < 7; c++) begin
            chk($sformatf("nat_loads_c%0d", c), {2'd0, loads()}, {2'd0, nat_loads[c]});
            if (c == 5) chk("nat_done_c5", {5'd0, hand_done, player_win_light, dealer_win_light}, 8'd0);
            if (c == 6) chk("nat_done_c6", {5'd0, hand_done, player_win_light, dealer_win_light}, 8'b110);
            tick();
        end

        // Full six-card hand: lights valid at cycle 10
        start_hand(vec[2]);
        for (int c = 0; c < 10; c++) tick();
        chk("full_c10", {5'd0, hand_done, player_win_light, dealer_win_light}, 8'b101);

        // Tie with deal_en stalls in S_D1 and S_P3
        start_hand(vec[5]);
        chk("stall_p1_load", {2'd0, loads()}, 8'b100000);
        tick();
        deal_en = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall_d1_hold%0d", k), {2'd0, loads()}, 8'd0);
            tick();
        end
        deal_en = 1'b1;
        #1;
        chk("stall_d1_resume", {2'd0, loads()}, 8'b010000);
        tick();
        chk("stall_p2", {2'd0, loads()}, 8'b001000);
        tick();
        chk("stall_d2", {2'd0, loads()}, 8'b000100);
        tick();
        chk("stall_chk", {2'd0, loads()}, 8'd0);
        tick();
        deal_en = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall_p3_hold%0d", k), {2'd0, loads()}, 8'd0);
            tick();
        end
        deal_en = 1'b1;
        #1;
        chk("stall_p3_resume", {2'd0, loads()}, 8'b000010);
        tick();
        tick();
        tick();
        chk("stall_tie_lights", {5'd0, hand_done, player_win_light, dealer_win_light}, 8'b111);

        // Reset mid-hand in S_P2
        start_hand(vec[5]);
        tick();
        tick();
        chk("mid_p2_load", {2'd0, loads()}, 8'b001000);
        reset = 1'b1;
        #1;
        chk("mid_reset_blocks_load", {2'd0, loads()}, 8'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_back_to_p1", {loads(), hand_done, player_win_light | dealer_win_light}, 8'b10000000);

        // Reset from S_DONE clears lights
        run_hand(5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("done_reset_clear", {5'd0, hand_done, player_win_light, dealer_win_light}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
